// File: rtl/id_ex_hazard_reg_pkg.sv
// id_ex_hazard_reg_pkg: decoder control encodings, field widths and register-field helpers
package id_ex_hazard_reg_pkg;
  localparam int ALUOP_W = 6;
  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;
  localparam logic [REG_W-1:0] REG_RA = 5'd31;
  typedef enum logic [1:0] {
    REGDST_RT = 2'b00,
    REGDST_RD = 2'b01,
    REGDST_RA = 2'b10
  } regdst_e;
  typedef enum logic [1:0] {
    MTR_ALU = 2'b00,
    MTR_MEM = 2'b01,
    MTR_PC4 = 2'b10
  } memtoreg_e;
  typedef enum logic [1:0] {
    SM_WORD = 2'b00,
    SM_HALF = 2'b01,
    SM_BYTE = 2'b10
  } storemode_e;
  // Packing order matches the concatenation used on the bus, so an all-zero word is a NOP.
  typedef struct packed {
    logic [1:0]         regdst;
    logic               alusrc;
    logic               memread;
    logic               memwrite;
    logic               regwrite;
    logic               branch;
    logic               jalmuxsel;
    logic [1:0]         memtoreg;
    logic [1:0]         storemode;
    logic [ALUOP_W-1:0] aluop;
  } ctrl_t;
  function automatic logic reg_hit(input logic [REG_W-1:0] a, input logic [REG_W-1:0] b);
    return (a != REG_ZERO) && (a == b);
  endfunction
  function automatic logic [REG_W-1:0] dest_mux(input logic [1:0] sel, input logic [REG_W-1:0] rt,
                                                input logic [REG_W-1:0] rd);
    return (sel == REGDST_RD) ? rd : (sel == REGDST_RA) ? REG_RA : rt;
  endfunction
endpackage

// File: rtl/id_ex_hazard_reg_if.sv
// id_ex_hazard_reg_if: ID-side inputs and EX-side registered outputs of the ID/EX stage
interface id_ex_hazard_reg_if
  import id_ex_hazard_reg_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int PERF_W = 16
);
  logic [1:0]         RegDst_in, RegDst_out;
  logic               ALUSrc_in, ALUSrc_out;
  logic               MemRead_in, MemRead_out;
  logic               MemWrite_in, MemWrite_out;
  logic               RegWrite_in, RegWrite_out;
  logic               Branch_in, Branch_out;
  logic               JalMuxSel_in, JalMuxSel_out;
  logic [1:0]         MemtoReg_in, MemtoReg_out;
  logic [1:0]         StoreMode_in, StoreMode_out;
  logic [ALUOP_W-1:0] ALUOp_in, ALUOp_out;
  logic [DATA_W-1:0]  PCPlus4_in, PCPlus4_out;
  logic [DATA_W-1:0]  ReadData1_in, ReadData1_out;
  logic [DATA_W-1:0]  ReadData2_in, ReadData2_out;
  logic [DATA_W-1:0]  SignExt_in, SignExt_out;
  logic [4:0]         Rs_in, Rs_out;
  logic [4:0]         Rt_in, Rt_out;
  logic [4:0]         Rd_in, Rd_out;
  logic               MEM_MemRead;
  logic [4:0]         MEM_WriteReg;
  logic               Flush;
  logic [4:0]         WriteReg_ex;
  logic               PCWrite;
  logic               IFIDWrite;
  logic [PERF_W-1:0]  StallCount;
  modport master(
    output RegDst_in, ALUSrc_in, MemRead_in, MemWrite_in, RegWrite_in, Branch_in, JalMuxSel_in,
           MemtoReg_in, StoreMode_in, ALUOp_in, PCPlus4_in, ReadData1_in, ReadData2_in, SignExt_in,
           Rs_in, Rt_in, Rd_in, MEM_MemRead, MEM_WriteReg, Flush,
    input  RegDst_out, ALUSrc_out, MemRead_out, MemWrite_out, RegWrite_out, Branch_out, JalMuxSel_out,
           MemtoReg_out, StoreMode_out, ALUOp_out, PCPlus4_out, ReadData1_out, ReadData2_out, SignExt_out,
           Rs_out, Rt_out, Rd_out, WriteReg_ex, PCWrite, IFIDWrite, StallCount
  );
  modport slave(
    input  RegDst_in, ALUSrc_in, MemRead_in, MemWrite_in, RegWrite_in, Branch_in, JalMuxSel_in,
           MemtoReg_in, StoreMode_in, ALUOp_in, PCPlus4_in, ReadData1_in, ReadData2_in, SignExt_in,
           Rs_in, Rt_in, Rd_in, MEM_MemRead, MEM_WriteReg, Flush,
    output RegDst_out, ALUSrc_out, MemRead_out, MemWrite_out, RegWrite_out, Branch_out, JalMuxSel_out,
           MemtoReg_out, StoreMode_out, ALUOp_out, PCPlus4_out, ReadData1_out, ReadData2_out, SignExt_out,
           Rs_out, Rt_out, Rd_out, WriteReg_ex, PCWrite, IFIDWrite, StallCount
  );
endinterface

// File: rtl/id_ex_hazard_reg_hazard_detect.sv
// id_ex_hazard_reg_hazard_detect: load-use and branch-operand hazard detection
module id_ex_hazard_reg_hazard_detect
  import id_ex_hazard_reg_pkg::*;
(
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] rt,
  input  logic             alusrc,
  input  logic             memwrite,
  input  logic             branch,
  input  logic             ex_memread,
  input  logic             ex_regwrite,
  input  logic [REG_W-1:0] ex_wr,
  input  logic             mem_memread,
  input  logic [REG_W-1:0] mem_wr,
  output logic             stall
);
  logic lu, br1, br2;
  // Stores read rt as data even though ALUSrc selects the immediate.
  always_comb begin
    lu = ex_memread && (reg_hit(ex_wr, rs) || (reg_hit(ex_wr, rt) && (!alusrc || memwrite)));
    br1 = branch && ex_regwrite && (reg_hit(ex_wr, rs) || reg_hit(ex_wr, rt));
    br2 = branch && mem_memread && (reg_hit(mem_wr, rs) || reg_hit(mem_wr, rt));
    stall = lu || br1 || br2;
  end
endmodule

// File: rtl/id_ex_hazard_reg.sv
// id_ex_hazard_reg: ID/EX pipeline register with bubble insertion, flush and stall counting
module id_ex_hazard_reg
  import id_ex_hazard_reg_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int PERF_W = 16
) (
  input logic             Clk,
  input logic             Reset,
  id_ex_hazard_reg_if.slave bus
);
  ctrl_t ctrl_d, ctrl_q;
  logic [DATA_W-1:0] pc4_q, rd1_q, rd2_q, sext_q;
  logic [REG_W-1:0]  rs_q, rt_q, rd_q, wr_ex;
  logic [PERF_W-1:0] cnt_q;
  logic              stall;
  assign ctrl_d = {bus.RegDst_in, bus.ALUSrc_in, bus.MemRead_in, bus.MemWrite_in, bus.RegWrite_in,
                   bus.Branch_in, bus.JalMuxSel_in, bus.MemtoReg_in, bus.StoreMode_in, bus.ALUOp_in};
  assign wr_ex = dest_mux(ctrl_q.regdst, rt_q, rd_q);
  id_ex_hazard_reg_hazard_detect u_hd (
    .rs         (bus.Rs_in),
    .rt         (bus.Rt_in),
    .alusrc     (bus.ALUSrc_in),
    .memwrite   (bus.MemWrite_in),
    .branch     (bus.Branch_in),
    .ex_memread (ctrl_q.memread),
    .ex_regwrite(ctrl_q.regwrite),
    .ex_wr      (wr_ex),
    .mem_memread(bus.MEM_MemRead),
    .mem_wr     (bus.MEM_WriteReg),
    .stall      (stall)
  );
  // Flush outranks stall: the killed instruction must not be counted as a bubble.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      ctrl_q <= '0;
      {pc4_q, rd1_q, rd2_q, sext_q, rs_q, rt_q, rd_q} <= '0;
      cnt_q <= '0;
    end else begin
      ctrl_q <= (bus.Flush || stall) ? '0 : ctrl_d;
      {pc4_q, rd1_q, rd2_q, sext_q, rs_q, rt_q, rd_q} <=
        {bus.PCPlus4_in, bus.ReadData1_in, bus.ReadData2_in, bus.SignExt_in, bus.Rs_in, bus.Rt_in, bus.Rd_in};
      if (stall && !bus.Flush && !(&cnt_q)) cnt_q <= cnt_q + PERF_W'(1);
    end
  end
  assign {bus.RegDst_out, bus.ALUSrc_out, bus.MemRead_out, bus.MemWrite_out, bus.RegWrite_out,
          bus.Branch_out, bus.JalMuxSel_out, bus.MemtoReg_out, bus.StoreMode_out, bus.ALUOp_out} = ctrl_q;
  assign bus.PCPlus4_out = pc4_q;
  assign bus.ReadData1_out = rd1_q;
  assign bus.ReadData2_out = rd2_q;
  assign bus.SignExt_out = sext_q;
  assign bus.Rs_out = rs_q;
  assign bus.Rt_out = rt_q;
  assign bus.Rd_out = rd_q;
  assign bus.WriteReg_ex = wr_ex;
  assign bus.PCWrite = !stall || bus.Flush;
  assign bus.IFIDWrite = !stall || bus.Flush;
  assign bus.StallCount = cnt_q;
endmodule
